// File: rtl/iq_pkg.sv
// iq_pkg: shared sizes, entry layout and helpers for the memory issue queue
package iq_pkg;
    localparam int IQ_MEM_SIZE = 8;
    localparam int DISPATCH_WIDTH = 2;
    localparam int PRF_INT_INDEX_SIZE = 6;
    localparam int PAYLOAD_WIDTH = 64;
    localparam int COUNT_WIDTH = $clog2(IQ_MEM_SIZE + 1);
    localparam int SLOT_WIDTH = $clog2(IQ_MEM_SIZE);
    typedef struct packed {
        logic                          valid;
        logic                          is_store;
        logic                          rs1_used;
        logic [PRF_INT_INDEX_SIZE-1:0] rs1;
        logic                          rs2_used;
        logic [PRF_INT_INDEX_SIZE-1:0] rs2;
        logic [PAYLOAD_WIDTH-1:0]      payload;
    } iq_mem_entry_t;
    function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [DISPATCH_WIDTH-1:0] bits);
        popcount = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) popcount = popcount + COUNT_WIDTH'(bits[l]);
    endfunction
endpackage

// File: rtl/iq_mem_select.sv
// iq_mem_select: picks the oldest ready slot that has no older store ahead of it
module iq_mem_select import iq_pkg::*; (
    input  logic [IQ_MEM_SIZE-1:0] ready,
    input  logic [IQ_MEM_SIZE-1:0] valid,
    input  logic [IQ_MEM_SIZE-1:0] is_store,
    output logic [IQ_MEM_SIZE-1:0] grant,
    output logic [SLOT_WIDTH-1:0]  index,
    output logic                   any
);
    logic older_store;
    always_comb begin
        grant = '0;
        index = '0;
        any = 1'b0;
        older_store = 1'b0;
        for (int i = 0; i < IQ_MEM_SIZE; i++) begin
            if (valid[i] && ready[i] && !older_store && !any) begin
                grant[i] = 1'b1;
                index = SLOT_WIDTH'(i);
                any = 1'b1;
            end
            older_store = older_store | (valid[i] && is_store[i]);
        end
    end
endmodule

// File: rtl/issue_queue_mem.sv
// issue_queue_mem: collapsing age-ordered load/store issue queue, one issue per cycle
module issue_queue_mem import iq_pkg::*; (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                clear,
    input  logic [DISPATCH_WIDTH-1:0]                           dispatch_valid,
    input  logic [DISPATCH_WIDTH-1:0]                           dispatch_is_store,
    input  logic [DISPATCH_WIDTH-1:0]                           dispatch_rs1_used,
    input  logic [DISPATCH_WIDTH-1:0]                           dispatch_rs2_used,
    input  logic [DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   dispatch_rs1,
    input  logic [DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   dispatch_rs2,
    input  logic [DISPATCH_WIDTH-1:0][PAYLOAD_WIDTH-1:0]        dispatch_payload,
    output logic                                                dispatch_ready,
    output logic [IQ_MEM_SIZE-1:0][PRF_INT_INDEX_SIZE-1:0]      sb_rs1_index,
    output logic [IQ_MEM_SIZE-1:0][PRF_INT_INDEX_SIZE-1:0]      sb_rs2_index,
    input  logic [IQ_MEM_SIZE-1:0]                              sb_rs1_busy,
    input  logic [IQ_MEM_SIZE-1:0]                              sb_rs2_busy,
    output logic                                                issue_valid,
    input  logic                                                issue_ready,
    output logic                                                issue_is_store,
    output logic [PRF_INT_INDEX_SIZE-1:0]                       issue_rs1,
    output logic [PRF_INT_INDEX_SIZE-1:0]                       issue_rs2,
    output logic [PAYLOAD_WIDTH-1:0]                            issue_payload,
    output logic [COUNT_WIDTH-1:0]                              count
);
    iq_mem_entry_t [IQ_MEM_SIZE-1:0] slots, slots_next;
    iq_mem_entry_t [IQ_MEM_SIZE:0]   ext;
    iq_mem_entry_t                   sel;
    logic [IQ_MEM_SIZE-1:0]          ready, valid, is_store, grant;
    logic [SLOT_WIDTH-1:0]           index;
    logic [COUNT_WIDTH-1:0]          base, tail, count_next;
    logic                            fire;

    always_comb begin
        for (int i = 0; i < IQ_MEM_SIZE; i++) begin
            valid[i] = slots[i].valid;
            is_store[i] = slots[i].is_store;
            ready[i] = slots[i].valid && (!slots[i].rs1_used || !sb_rs1_busy[i])
                                      && (!slots[i].rs2_used || !sb_rs2_busy[i]);
            sb_rs1_index[i] = slots[i].valid ? slots[i].rs1 : '0;
            sb_rs2_index[i] = slots[i].valid ? slots[i].rs2 : '0;
        end
    end

    iq_mem_select u_select (
        .ready    (ready),
        .valid    (valid),
        .is_store (is_store),
        .grant    (grant),
        .index    (index),
        .any      (issue_valid)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < IQ_MEM_SIZE; i++) if (grant[i]) sel = slots[i];
    end

    assign issue_is_store = sel.is_store;
    assign issue_rs1 = sel.rs1;
    assign issue_rs2 = sel.rs2;
    assign issue_payload = sel.payload;
    assign dispatch_ready = count <= COUNT_WIDTH'(IQ_MEM_SIZE - DISPATCH_WIDTH);
    assign fire = issue_valid && issue_ready;
    assign ext = {iq_mem_entry_t'('0), slots};

    // collapse over the fired slot, then append accepted lanes behind the new tail
    always_comb begin
        for (int i = 0; i < IQ_MEM_SIZE; i++)
            slots_next[i] = (fire && SLOT_WIDTH'(i) >= index) ? ext[i+1] : slots[i];
        base = count - COUNT_WIDTH'(fire);
        tail = base;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (dispatch_ready && dispatch_valid[l]) begin
                slots_next[tail[SLOT_WIDTH-1:0]] = '{valid: 1'b1, is_store: dispatch_is_store[l],
                    rs1_used: dispatch_rs1_used[l], rs1: dispatch_rs1[l],
                    rs2_used: dispatch_rs2_used[l], rs2: dispatch_rs2[l],
                    payload: dispatch_payload[l]};
                tail = tail + COUNT_WIDTH'(1);
            end
        end
        count_next = base + (dispatch_ready ? popcount(dispatch_valid) : '0);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            slots <= '0;
            count <= '0;
        end else begin
            slots <= slots_next;
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_issue_queue_mem.sv
// tb_issue_queue_mem: table-driven directed check of the memory issue queue
module tb_issue_queue_mem;
    logic clock = 1'b0;
    logic reset, clear, issue_ready;
    logic [1:0] dispatch_valid, dispatch_is_store, dispatch_rs1_used, dispatch_rs2_used;
    logic [1:0][5:0] dispatch_rs1, dispatch_rs2;
    logic [1:0][63:0] dispatch_payload;
    logic dispatch_ready, issue_valid, issue_is_store;
    logic [7:0][5:0] sb_rs1_index, sb_rs2_index;
    logic [7:0] sb_rs1_busy, sb_rs2_busy;
    logic [5:0] issue_rs1, issue_rs2;
    logic [63:0] issue_payload, prf_busy;
    logic [3:0] count;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rst, clr;
        logic [1:0] dv, st;
        logic [5:0] r1a, r1b, r2a, r2b;
        logic [63:0] busy;
        logic ir;
        int cnt;
        logic drdy, iv;
        logic [5:0] irs1, irs2;
        logic ist;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    issue_queue_mem dut (
        .clock(clock), .reset(reset), .clear(clear),
        .dispatch_valid(dispatch_valid), .dispatch_is_store(dispatch_is_store),
        .dispatch_rs1_used(dispatch_rs1_used), .dispatch_rs2_used(dispatch_rs2_used),
        .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2), .dispatch_payload(dispatch_payload),
        .dispatch_ready(dispatch_ready), .sb_rs1_index(sb_rs1_index), .sb_rs2_index(sb_rs2_index),
        .sb_rs1_busy(sb_rs1_busy), .sb_rs2_busy(sb_rs2_busy), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_is_store(issue_is_store), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_payload(issue_payload), .count(count)
    );

    // scoreboard model: busy bit per physical register
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sb_rs1_busy[i] = prf_busy[sb_rs1_index[i]];
            sb_rs2_busy[i] = prf_busy[sb_rs2_index[i]];
        end
    end

    always @(posedge clock)
        if (!reset && !clear) assert (!(|dispatch_valid && !dispatch_ready)) else $error("dispatch while not ready");

    function automatic logic [63:0] pay(input logic [5:0] r);
        return 64'hFACE_0000_0000_0000 | 64'(r);
    endfunction

    function automatic logic [63:0] b(input int n);
        return 64'b1 << n;
    endfunction

    function automatic vec_t v(input logic rst, clr, input logic [1:0] dv, st, input logic [5:0] r1a, r1b, r2a, r2b,
                               input logic [63:0] busy, input logic ir, input int cnt, input logic drdy, iv,
                               input logic [5:0] irs1, irs2, input logic ist);
        return '{rst: rst, clr: clr, dv: dv, st: st, r1a: r1a, r1b: r1b, r2a: r2a, r2b: r2b, busy: busy, ir: ir,
                 cnt: cnt, drdy: drdy, iv: iv, irs1: irs1, irs2: irs2, ist: ist};
    endfunction

    task automatic apply(input vec_t x);
        reset = x.rst;
        clear = x.clr;
        dispatch_valid = x.dv;
        dispatch_is_store = x.st;
        dispatch_rs1 = {x.r1b, x.r1a};
        dispatch_rs2 = {x.r2b, x.r2a};
        dispatch_rs1_used = {x.r1b != 0, x.r1a != 0};
        dispatch_rs2_used = {x.r2b != 0, x.r2a != 0};
        dispatch_payload = {pay(x.r1b), pay(x.r1a)};
        prf_busy = x.busy;
        issue_ready = x.ir;
    endtask

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    initial begin
        logic [63:0] f, g;
        f = 64'h1FC00;
        g = b(12) | b(13) | b(14) | b(15) | b(16) | b(20) | b(21);
        //                 rst clr dv     st     r1a r1b r2a r2b busy                      ir  cnt drdy iv irs1 irs2 ist
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b0, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 5,  7,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 2, 1, 1, 5,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 1, 1, 1, 7,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 3,  4,  0,  0,  b(3),                      1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  b(3),                      1'b1, 2, 1, 1, 4,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  b(3),                      1'b1, 1, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 1, 1, 1, 3,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b01, 0,  2,  9,  0,  b(9),                      1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  b(9),                      1'b1, 2, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  b(9),                      1'b1, 2, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b0, 2, 1, 1, 0,  9, 1));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 2, 1, 1, 0,  9, 1));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 1, 1, 1, 2,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 10, 11, 0,  0,  f,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 12, 13, 0,  0,  f,                         1'b1, 2, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 14, 15, 0,  0,  f,                         1'b1, 4, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b01, 2'b00, 16, 0,  0,  0,  f,                         1'b1, 6, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  f,                         1'b1, 7, 0, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  f & ~b(10),                1'b1, 7, 0, 1, 10, 0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  f & ~b(10),                1'b1, 6, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 20, 21, 0,  0,  g,                         1'b1, 6, 1, 1, 11, 0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  g,                         1'b1, 7, 0, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  g & ~b(12),                1'b1, 7, 0, 1, 12, 0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  g & ~b(12) & ~b(13),       1'b1, 6, 1, 1, 13, 0, 0));
        vecs.push_back(v(0, 1, 2'b11, 2'b00, 30, 31, 0,  0,  g & ~b(12) & ~b(13) & ~b(14), 1'b1, 5, 1, 1, 14, 0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b10, 2'b00, 0,  25, 0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 1, 1, 1, 25, 0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b11, 2'b00, 40, 41, 0,  0,  b(40) | b(41),             1'b1, 0, 1, 0, 0,  0, 0));
        vecs.push_back(v(1, 0, 2'b11, 2'b00, 42, 43, 0,  0,  b(40) | b(41),             1'b1, 2, 1, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, 2'b00, 2'b00, 0,  0,  0,  0,  0,                         1'b1, 0, 1, 0, 0,  0, 0));

        apply(v(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        for (int k = 0; k < vecs.size(); k++) begin
            #1 apply(vecs[k]);
            @(negedge clock);
            chk("count", k, 64'(count), 64'(vecs[k].cnt));
            chk("dispatch_ready", k, 64'(dispatch_ready), 64'(vecs[k].drdy));
            chk("issue_valid", k, 64'(issue_valid), 64'(vecs[k].iv));
            if (vecs[k].iv || k == 0) begin
                chk("issue_rs1", k, 64'(issue_rs1), 64'(vecs[k].irs1));
                chk("issue_rs2", k, 64'(issue_rs2), 64'(vecs[k].irs2));
                chk("issue_is_store", k, 64'(issue_is_store), 64'(vecs[k].ist));
                chk("issue_payload", k, issue_payload, vecs[k].iv ? pay(vecs[k].irs1) : 64'h0);
            end
            @(posedge clock);
        end

        // scoreboard index outputs: empty after reset, then mirror slot contents
        #1 apply(v(0, 0, 2'b11, 2'b00, 5, 7, 6, 8, b(5) | b(6) | b(7) | b(8), 1'b1, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            chk("sb_rs1_index_empty", i, 64'(sb_rs1_index[i]), 64'h0);
            chk("sb_rs2_index_empty", i, 64'(sb_rs2_index[i]), 64'h0);
        end
        @(posedge clock);
        #1 apply(v(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, b(5) | b(6) | b(7) | b(8), 1'b1, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        chk("sb_count", 0, 64'(count), 64'd2);
        chk("sb_issue_valid", 0, 64'(issue_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("sb_rs1_index", i, 64'(sb_rs1_index[i]), i == 0 ? 64'd5 : i == 1 ? 64'd7 : 64'd0);
            chk("sb_rs2_index", i, 64'(sb_rs2_index[i]), i == 0 ? 64'd6 : i == 1 ? 64'd8 : 64'd0);
        end
        @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
